// File: rtl/sens_transmitter.sv
// Serial sample transmitter: accepts a 16-bit sample on a valid/ready
// handshake and sends it as back-to-back 8N1 bytes (low, high, optional
// XOR checksum), one bit per clk_en_i pulse, then holds the line idle for
// FRAME_GAP bit periods before it accepts the next sample.
module sens_transmitter #(
    parameter int unsigned FRAME_GAP   = 1,
    parameter bit          CHECKSUM_EN = 1'b0
) (
    input  logic        clk_in_i,
    input  logic        reset_i,
    input  logic        clk_en_i,
    input  logic [15:0] sens_data_i,
    input  logic        sens_valid_i,
    output logic        sens_ready_o,
    output logic        sens_tx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_START,
        S_DATA,
        S_STOP,
        S_GAP
    } state_t;

    localparam logic [1:0] N_BYTES  = CHECKSUM_EN ? 2'd3 : 2'd2;
    localparam logic [3:0] GAP_LAST = (FRAME_GAP == 0) ? 4'd0 : 4'(FRAME_GAP - 1);

    state_t      state_q, state_d;
    logic [23:0] shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic [7:0]  checksum;

    assign checksum     = CHECKSUM_EN ? (sens_data_i[7:0] ^ sens_data_i[15:8]) : 8'h00;
    assign sens_ready_o = ready_q;
    assign sens_tx_o    = tx_q;
    assign busy_o       = busy_q;

    // Next-state and next-output computation; line changes only on clk_en_i
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_d       = tx_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (sens_valid_i && ready_q) begin
                    shift_d    = {checksum, sens_data_i};
                    byte_cnt_d = N_BYTES;
                    ready_d    = 1'b0;
                    state_d    = S_ARMED;
                end
            end
            S_ARMED: begin
                if (clk_en_i) begin
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_en_i) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[23:1]};
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (clk_en_i) begin
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[23:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (clk_en_i) begin
                    if (byte_cnt_q > 2'd1) begin
                        byte_cnt_d = byte_cnt_q - 2'd1;
                        tx_d       = 1'b0;
                        state_d    = S_START;
                    end else begin
                        byte_cnt_d = 2'd0;
                        busy_d     = 1'b0;
                        if (FRAME_GAP > 0) begin
                            gap_cnt_d = 4'd0;
                            state_d   = S_GAP;
                        end else begin
                            ready_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_GAP: begin
                if (clk_en_i) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = 4'd0;
                        ready_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_in_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_sens_transmitter.sv
// Directed bench for sens_transmitter: three instances cover the default
// build, the checksum build and the zero-gap build.
module tb_sens_transmitter;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        valid [3];
    logic [15:0] data  [3];
    logic        ready_w [3];
    logic        tx_w    [3];
    logic        busy_w  [3];

    int n_assert = 0;
    int n_fail   = 0;
    int en_period = 2;
    int en_cnt    = 0;
    logic was_en  = 1'b0;

    sens_transmitter #(.FRAME_GAP(1), .CHECKSUM_EN(1'b0)) u_dut0 (
        .clk_in_i(clk), .reset_i(reset), .clk_en_i(clk_en),
        .sens_data_i(data[0]), .sens_valid_i(valid[0]),
        .sens_ready_o(ready_w[0]), .sens_tx_o(tx_w[0]), .busy_o(busy_w[0])
    );

    sens_transmitter #(.FRAME_GAP(1), .CHECKSUM_EN(1'b1)) u_dut1 (
        .clk_in_i(clk), .reset_i(reset), .clk_en_i(clk_en),
        .sens_data_i(data[1]), .sens_valid_i(valid[1]),
        .sens_ready_o(ready_w[1]), .sens_tx_o(tx_w[1]), .busy_o(busy_w[1])
    );

    sens_transmitter #(.FRAME_GAP(0), .CHECKSUM_EN(1'b0)) u_dut2 (
        .clk_in_i(clk), .reset_i(reset), .clk_en_i(clk_en),
        .sens_data_i(data[2]), .sens_valid_i(valid[2]),
        .sens_ready_o(ready_w[2]), .sens_tx_o(tx_w[2]), .busy_o(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        was_en = clk_en;
        @(posedge clk);
        #1;
        en_cnt = (en_cnt + 1) % en_period;
        clk_en = (en_cnt == 0);
    endtask

    task automatic set_period(input int p);
        en_period = p;
        en_cnt    = 0;
        clk_en    = 1'b1;
    endtask

    task automatic next_en_edge();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!was_en && n < 64);
        if (!was_en) chk("en_edge_timeout", 1'b0, 1'b1);
    endtask

    task automatic get(input int s, output logic t, output logic r, output logic b);
        t = tx_w[s];
        r = ready_w[s];
        b = busy_w[s];
    endtask

    // Line bit j of a frame: start 0, eight data bits LSB first, stop 1
    function automatic logic frame_bit(input logic [23:0] bytes, input int j);
        int p;
        int b;
        p = j % 10;
        b = j / 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return bytes[b * 8 + p - 1];
    endfunction

    task automatic run_frame(input int s, input logic [15:0] d, input int nb,
                             input int gap, input bit offer);
        logic t, r, b;
        logic [23:0] bytes;
        bytes = {d[7:0] ^ d[15:8], d};
        get(s, t, r, b);
        chk("ready_before_accept", r, 1'b1);
        valid[s] = 1'b1;
        data[s]  = d;
        step();
        valid[s] = 1'b0;
        get(s, t, r, b);
        chk("ready_low_after_accept", r, 1'b0);
        chk("tx_high_armed", t, 1'b1);
        chk("busy_low_armed", b, 1'b0);
        if (offer) begin
            valid[s] = 1'b1;
            data[s]  = 16'hBEEF;
        end
        for (int j = 0; j < 10 * nb; j++) begin
            next_en_edge();
            get(s, t, r, b);
            chk($sformatf("tx_bit%0d", j), t, frame_bit(bytes, j));
            chk($sformatf("busy_bit%0d", j), b, 1'b1);
            chk($sformatf("ready_bit%0d", j), r, 1'b0);
        end
        next_en_edge();
        get(s, t, r, b);
        chk("busy_fall", b, 1'b0);
        chk("tx_idle_after_stop", t, 1'b1);
        chk("ready_after_stop", r, (gap == 0));
        for (int g = 1; g <= gap; g++) begin
            next_en_edge();
            get(s, t, r, b);
            chk($sformatf("ready_gap%0d", g), r, (g == gap));
            chk($sformatf("tx_gap%0d", g), t, 1'b1);
        end
        if (offer) valid[s] = 1'b0;
    endtask

    initial begin
        logic t, r, b;
        logic [23:0] bytes;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 16'h0000;
        end
        clk_en = 1'b0;
        reset  = 1'b1;

        // Reset held two cycles with clk_en toggling
        set_period(2);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            get(i, t, r, b);
            chk($sformatf("reset_tx_%0d", i), t, 1'b1);
            chk($sformatf("reset_ready_%0d", i), r, 1'b1);
            chk($sformatf("reset_busy_%0d", i), b, 1'b0);
        end
        reset = 1'b0;
        step();

        // Basic frame, enable every 4 cycles
        set_period(4);
        step();
        run_frame(0, 16'h1234, 2, 1, 1'b0);

        // Offer during a frame is ignored, then accepted once ready
        step();
        run_frame(0, 16'h1234, 2, 1, 1'b1);
        get(0, t, r, b);
        chk("ready_before_reoffer", r, 1'b1);
        run_frame(0, 16'hBEEF, 2, 1, 1'b0);

        // Checksum build: bytes 00, FF, FF over 30 bit periods
        set_period(3);
        step();
        run_frame(1, 16'hFF00, 3, 1, 1'b0);

        // Reset during bit 7 of byte 0
        set_period(4);
        step();
        valid[0] = 1'b1;
        data[0]  = 16'h1234;
        step();
        valid[0] = 1'b0;
        for (int k = 0; k < 9; k++) next_en_edge();
        get(0, t, r, b);
        chk("midframe_tx_bit7", t, 1'b0);
        chk("midframe_busy", b, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        get(0, t, r, b);
        chk("midreset_tx", t, 1'b1);
        chk("midreset_ready", r, 1'b1);
        chk("midreset_busy", b, 1'b0);
        step();
        run_frame(0, 16'h0001, 2, 1, 1'b0);

        // Back-to-back frames, enable tied high, zero gap
        set_period(1);
        step();
        valid[2] = 1'b1;
        data[2]  = 16'hA55A;
        for (int f = 0; f < 2; f++) begin
            bytes = (f == 0) ? 24'h00A55A : 24'h000FF0;
            for (int k = 0; k < 22; k++) begin
                get(2, t, r, b);
                chk($sformatf("b2b_ready_f%0d_k%0d", f, k), r, (k == 0));
                chk($sformatf("b2b_tx_f%0d_k%0d", f, k), t,
                    (k < 2) ? 1'b1 : frame_bit(bytes, k - 2));
                step();
                if (f == 0 && k == 0) data[2] = 16'h0FF0;
            end
        end
        valid[2] = 1'b0;
        get(2, t, r, b);
        chk("b2b_ready_end", r, 1'b1);
        step();
        step();
        get(2, t, r, b);
        chk("b2b_ready_idle", r, 1'b1);
        chk("b2b_tx_idle", t, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sens_transmitter.md
# sens_transmitter

Serial transmitter producing the sensor sample stream consumed by the sensor receiver. Accepts a 16-bit sample over a valid/ready handshake and shifts it out as back-to-back 8N1 bytes at one bit per `clk_en_i` pulse, the shared serial-rate enable. Used for loopback tests, the sensor-emulator build, and bench stimulus of the PID sensor path.

## Interface
Parameters:
- `FRAME_GAP`, default 1: idle bit periods, with the line high, after the last stop bit and before the next frame can start. Range 0–15.
- `CHECKSUM_EN`, default 0: when 1, a third byte is appended, equal to low byte XOR high byte.

Ports:
- `clk_in_i`  input  1  system clock; all logic is on its rising edge.
- `reset_i`  input  1  synchronous, active-high reset.
- `clk_en_i`  input  1  bit-rate enable; a one-cycle pulse per bit period. Holding it high continuously is legal.
- `sens_data_i`  input  16  sample to send.
- `sens_valid_i`  input  1  sample-offer strobe.
- `sens_ready_o`  output  1  block can accept a sample.
- `sens_tx_o`  output  1  serial line; idles high.
- `busy_o`  output  1  high from the start bit through the last stop bit.

## Operation
- Reset values: `sens_tx_o`=1, `sens_ready_o`=1, `busy_o`=0, state IDLE, all counters 0.
- Accept: occurs in any cycle where `sens_valid_i & sens_ready_o`, whether or not `clk_en_i` is high in that cycle.
  - `sens_data_i` is latched into a shift register.
  - The byte count N is latched as 2, or 3 when `CHECKSUM_EN`=1.
  - `sens_ready_o` goes 0 in the next cycle.
- While `sens_ready_o`=0, `sens_valid_i` and `sens_data_i` are ignored. A frame in flight is never altered.
- States: IDLE → ARMED → START → DATA → STOP → (START for the next byte | GAP | IDLE).
  - ARMED: entered on accept; exits on the first `clk_en_i` strictly after the accept cycle.
  - START: `sens_tx_o`=0 for one bit period.
  - DATA: 8 bit periods, LSB first; a 3-bit counter goes 0→7.
  - STOP: `sens_tx_o`=1 for one bit period.
  - After STOP: if bytes remain, go straight to START with no idle bit. Otherwise go to GAP if `FRAME_GAP`>0, else IDLE.
  - GAP: counts `FRAME_GAP` bit periods with `sens_tx_o`=1, then goes to IDLE.
- Byte order: low byte `[7:0]`, then high byte `[15:8]`, then the checksum `[7:0]^[15:8]` when enabled.
- All state transitions and line changes happen only in cycles where `clk_en_i`=1.
- `sens_tx_o` is registered and is a pure flop output, with no combinational path from the inputs.
- `busy_o` is registered:
  - rises with the start bit of byte 0;
  - falls when the last stop bit ends.
- `sens_ready_o` rises in IDLE entry, registered. A new accept is possible in the same cycle `sens_ready_o` is first seen high.
- Reset during any state takes effect at the next edge:
  - outputs return to their reset values;
  - the partial frame is abandoned;
  - no stop bit is forced.

## Timing
- Let accept occur in cycle A, and let E1, E2, … be the clock edges at which `clk_en_i`=1, counting after A.
- `sens_tx_o` falls at E1 (the start bit of byte 0). `busy_o` rises at E1.
- Bit j of the frame (j=0…10N−1) is driven from edge Ej+1 until Ej+2.
- `busy_o` falls at E(10N+1).
- `sens_ready_o` rises at E(10N+1+`FRAME_GAP`).
- Frame length on the line is 10N bit periods, plus `FRAME_GAP` idle periods.
- With `clk_en_i` tied high, `FRAME_GAP`=1 and N=2:
  - accept at cycle 0;
  - start bit visible in cycles 2–2;
  - line frame spans cycles 2–21;
  - `sens_ready_o`=1 in cycle 23.
- Accept-to-next-accept minimum is 10N+`FRAME_GAP`+2 enable periods.
- A `clk_en_i` pulse coincident with the accept cycle is not used for this frame.

## Test plan
- **Reset:** assert `reset_i` for 2 cycles. Required: `sens_tx_o`=1, `sens_ready_o`=1, `busy_o`=0, with `clk_en_i` toggling.
- **Basic frame:** 0x1234, `CHECKSUM_EN`=0, `clk_en_i` every 4 cycles. Required line sequence, one bit per pulse:
  - 0, then 0,0,1,0,1,1,0,0, then 1 (byte 0x34);
  - 0, then 0,1,0,0,1,0,0,0, then 1 (byte 0x12);
  - `sens_ready_o` high 21 enables after E1.
- **Checksum:** `CHECKSUM_EN`=1, sample 0xFF00. Required bytes on the line: 0x00, 0xFF, 0xFF. `busy_o` stays high for exactly 30 bit periods.
- **Busy offer:** offer 0xBEEF while a frame is in flight. Required: ignored, and the frame is unchanged. Re-offer 0xBEEF after `sens_ready_o` rises. Required: accepted, and 0xEF then 0xBE are sent.
- **Reset mid-frame:** assert `reset_i` during bit 7 of byte 0. Required: `sens_tx_o`=1 and `sens_ready_o`=1 the next cycle. A following 0x0001 is sent cleanly.
- **Back-to-back:** `clk_en_i` tied high, `sens_valid_i` held high, `FRAME_GAP`=0. Required: consecutive frames with no idle bit beyond the 2-cycle ARMED/accept overhead, and `sens_ready_o` high for exactly one cycle per frame.
